epsilon_greedy_selector: RTL and testbench

Sequential, parametrised epsilon-greedy action selector for the Q-learning agent.
- Accepts one Q-table row (NUM_ACTIONS packed Q values) plus an epsilon threshold through a valid/ready request handshake.
- Scans the row for the argmax, one slot per cycle, and draws exploration randomness from an internal seedable 16-bit LFSR.
- Returns a 1-based action with explore/exploit flag and row maximum through a valid/ready result handshake to the agent controller.

---
 rtl/epsilon_greedy_selector.sv | 205 ++++++++++++++++++++
 tb/tb_epsilon_greedy_selector.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/epsilon_greedy_selector.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : epsilon_greedy_selector
// Purpose  : Sequential epsilon-greedy action selector. Captures one Q-table
//            row and an epsilon threshold, scans the row one slot per cycle
//            for the argmax (ties go to the lowest slot), and decides between
//            exploring (random action from an internal 16-bit Galois LFSR) and
//            exploiting (greedy action).
// Ports    : clk, rst_n              - clock, synchronous active-low reset
//            req_valid/req_ready     - request handshake (ready only in IDLE)
//            q_values, epsilon       - Q row (slot i at [i*Q_WIDTH +: Q_WIDTH])
//                                      and exploration threshold
//            seed_load, seed         - reseed the LFSR (zero seed -> LFSR_SEED)
//            action_valid/ready      - result handshake
//            action, explored,       - 1-based action, explore flag and
//            max_value                 row maximum
// Revision : 1.0 - initial release
// ============================================================================
module epsilon_greedy_selector #(
  parameter int          NUM_ACTIONS = 4,
  parameter int          Q_WIDTH     = 16,
  parameter int          EPS_WIDTH   = 16,
  parameter int          ACT_WIDTH   = 4,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [NUM_ACTIONS*Q_WIDTH-1:0] q_values,
  input  logic [EPS_WIDTH-1:0]           epsilon,
  input  logic                           seed_load,
  input  logic [15:0]                    seed,
  output logic                           action_valid,
  input  logic                           action_ready,
  output logic [ACT_WIDTH-1:0]           action,
  output logic                           explored,
  output logic [Q_WIDTH-1:0]             max_value
);

  localparam int IDX_W = $clog2(NUM_ACTIONS);

  localparam logic [1:0]  c_IDLE      = 2'd0;
  localparam logic [1:0]  c_SCAN      = 2'd1;
  localparam logic [1:0]  c_DONE      = 2'd2;
  localparam logic [15:0] c_LFSR_MASK = 16'hB400;  // x^16+x^14+x^13+x^11+1

  logic [1:0]             r_state;
  logic [1:0]             w_state_nxt;

  logic [15:0]            r_lfsr;
  logic [15:0]            w_lfsr_shift;

  logic [Q_WIDTH-1:0]     r_q [NUM_ACTIONS];
  logic [EPS_WIDTH-1:0]   r_eps;
  logic [15:0]            r_rand;
  logic [IDX_W-1:0]       r_idx;
  logic                   r_last;
  logic [IDX_W-1:0]       r_best_idx;
  logic [Q_WIDTH-1:0]     r_best_val;

  logic [ACT_WIDTH-1:0]   r_action;
  logic                   r_explored;
  logic [Q_WIDTH-1:0]     r_max;

  logic                   w_explore;
  logic [15:0]            w_prod;
  logic [IDX_W-1:0]       w_explore_slot;
  logic [IDX_W-1:0]       w_sel_slot;
  logic [ACT_WIDTH-1:0]   w_action;
  logic                   w_unused_bits;

  // --------------------------------------------------------------------------
  // LFSR: free-running in every state; a reseed wins over the shift.
  // --------------------------------------------------------------------------
  assign w_lfsr_shift = r_lfsr[0] ? ((r_lfsr >> 1) ^ c_LFSR_MASK) : (r_lfsr >> 1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lfsr <= LFSR_SEED;
    end else if (seed_load) begin
      // An all-zero state would lock the LFSR, so fall back to the default.
      r_lfsr <= (seed == 16'd0) ? LFSR_SEED : seed;
    end else begin
      r_lfsr <= w_lfsr_shift;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (req_valid)    w_state_nxt = c_SCAN;
      c_SCAN:  if (r_last)       w_state_nxt = c_DONE;
      c_DONE:  if (action_ready) w_state_nxt = c_IDLE;
      default:                   w_state_nxt = c_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    req_ready    = 1'b0;
    action_valid = 1'b0;
    case (r_state)
      c_IDLE:  req_ready    = 1'b1;
      c_DONE:  action_valid = 1'b1;
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Explore decision and action mapping, all from the captured random word.
  // The explore slot is a multiply-and-take-high-byte scaling of R[15:8]
  // into 0..NUM_ACTIONS-1, which avoids a modulo.
  // --------------------------------------------------------------------------
  assign w_explore      = (r_eps > r_rand[EPS_WIDTH-1:0]);
  assign w_prod         = {8'd0, r_rand[15:8]} * 16'(NUM_ACTIONS);
  assign w_explore_slot = w_prod[8 +: IDX_W];
  assign w_sel_slot     = w_explore ? w_explore_slot : r_best_idx;
  // Slot 0 maps to the highest action number.
  assign w_action       = ACT_WIDTH'(NUM_ACTIONS) - ACT_WIDTH'(w_sel_slot);

  // Product high bits are structurally zero and the low byte is discarded;
  // random bits outside the epsilon/explore fields may be unused for small
  // EPS_WIDTH.
  assign w_unused_bits  = ^{w_prod, r_rand};

  // --------------------------------------------------------------------------
  // Datapath: capture, argmax scan, result registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ACTIONS; i++) begin
        r_q[i] <= '0;
      end
      r_eps      <= '0;
      r_rand     <= '0;
      r_idx      <= '0;
      r_last     <= 1'b0;
      r_best_idx <= '0;
      r_best_val <= '0;
      r_action   <= '0;
      r_explored <= 1'b0;
      r_max      <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (req_valid) begin
            for (int i = 0; i < NUM_ACTIONS; i++) begin
              r_q[i] <= q_values[i*Q_WIDTH +: Q_WIDTH];
            end
            r_eps      <= epsilon;
            r_rand     <= r_lfsr;
            r_idx      <= '0;
            r_last     <= 1'b0;
            r_best_idx <= '0;
            r_best_val <= q_values[0 +: Q_WIDTH];
          end
        end
        c_SCAN: begin
          if (!r_last) begin
            // Strict compare keeps the earliest slot on ties.
            if (r_q[r_idx] > r_best_val) begin
              r_best_idx <= r_idx;
              r_best_val <= r_q[r_idx];
            end
            if (r_idx == IDX_W'(NUM_ACTIONS - 1)) begin
              r_last <= 1'b1;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end else begin
            // All slots scanned: publish the result as DONE is entered.
            r_action   <= w_action;
            r_explored <= w_explore;
            r_max      <= r_best_val;
          end
        end
        default: ;
      endcase
    end
  end

  assign action    = r_action;
  assign explored  = r_explored;
  assign max_value = r_max;

endmodule
`default_nettype wire

// File: tb/tb_epsilon_greedy_selector.sv
`default_nettype none
`timescale 1ns/1ps
module tb_epsilon_greedy_selector;

  localparam int N = 4;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          req_valid, req_ready;
  logic [N*16-1:0] q_values;
  logic [15:0]   epsilon;
  logic          seed_load;
  logic [15:0]   seed;
  logic          action_valid, action_ready;
  logic [3:0]    action;
  logic          explored;
  logic [15:0]   max_value;

  logic          req_valid6, req_ready6, action_valid6, action_ready6, explored6;
  logic [47:0]   q6;
  logic [7:0]    eps6, max6;
  logic [2:0]    action6;

  epsilon_greedy_selector dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .q_values(q_values), .epsilon(epsilon), .seed_load(seed_load), .seed(seed),
    .action_valid(action_valid), .action_ready(action_ready), .action(action),
    .explored(explored), .max_value(max_value)
  );

  epsilon_greedy_selector #(.NUM_ACTIONS(6), .Q_WIDTH(8), .EPS_WIDTH(8), .ACT_WIDTH(3)) dut6 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid6), .req_ready(req_ready6),
    .q_values(q6), .epsilon(eps6), .seed_load(seed_load), .seed(seed),
    .action_valid(action_valid6), .action_ready(action_ready6), .action(action6),
    .explored(explored6), .max_value(max6)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  // Returns {action[3:0], explored, max[15:0]} for one request.
  function automatic logic [20:0] predict(input logic [N*16-1:0] q, input logic [15:0] eps,
                                          input logic [15:0] r);
    int best = 0;
    int slot;
    logic ex;
    for (int k = 1; k < N; k++)
      if (q[k*16 +: 16] > q[best*16 +: 16]) best = k;
    ex   = eps > r;
    slot = (int'(r[15:8]) * N) / 256;
    return {4'(N - (ex ? slot : best)), ex, q[best*16 +: 16]};
  endfunction

  logic        m_en = 1'b0;
  logic [15:0] m_lfsr;
  int          m_cd;
  logic        m_valid;
  logic [20:0] m_pend, m_out;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_lfsr  <= 16'hACE1;
      m_cd    <= 0;
      m_valid <= 1'b0;
      m_out   <= '0;
      m_pend  <= '0;
    end else begin
      m_lfsr <= seed_load ? ((seed == 16'd0) ? 16'hACE1 : seed) : lfsr_step(m_lfsr);
      if (!m_valid && m_cd == 0 && req_valid) begin
        m_pend <= predict(q_values, epsilon, m_lfsr);
        m_cd   <= N + 1;
      end else if (m_cd > 0) begin
        m_cd <= m_cd - 1;
        if (m_cd == 1) begin
          m_valid <= 1'b1;
          m_out   <= m_pend;
        end
      end else if (m_valid && action_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_en) begin
      checks++;
      if ({action_valid, req_ready, action, explored, max_value} !==
          {m_valid, (!m_valid && m_cd == 0), m_out}) begin
        failures++;
        $display("FAIL model_cmp t=%0t actual v=%b rdy=%b act=%0d exp=%b max=%0h required v=%b rdy=%b act=%0d exp=%b max=%0h",
                 $time, action_valid, req_ready, action, explored, max_value,
                 m_valid, (!m_valid && m_cd == 0), m_out[20:17], m_out[16], m_out[15:0]);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic run_req(input logic [N*16-1:0] q, input logic [15:0] eps, input bit consume,
                         output int lat, output logic [3:0] a, output logic e, output logic [15:0] mx);
    int n = 0;
    q_values  = q;
    epsilon   = eps;
    req_valid = 1'b1;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_wait", req_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    while (!action_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("result_wait", action_valid, 1'b1);
    a  = action;
    e  = explored;
    mx = max_value;
    if (consume) begin
      action_ready = 1'b1;
      @(negedge clk);
      action_ready = 1'b0;
    end
  endtask

  int          lat;
  logic [3:0]  a;
  logic        e;
  logic [15:0] mx;
  int          hist [16];
  logic [4:0]  seq1 [8];
  logic [4:0]  seq2 [8];

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog timeout t=%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, cyc, nexp, nonzero_max, seen;
    rst_n = 1'b0; req_valid = 1'b0; action_ready = 1'b0; seed_load = 1'b0; seed = '0;
    epsilon = '0; q_values = '0; req_valid6 = 1'b0; action_ready6 = 1'b0; q6 = '0; eps6 = '0;

    // 1. reset
    @(posedge clk);
    m_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_action_valid", action_valid, 1'b0);
    check("rst_action", action, 4'd0);
    check("rst_explored", explored, 1'b0);
    check("rst_max_value", max_value, 16'd0);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_lfsr", dut.r_lfsr, 16'hACE1);
    check("rst_model_lfsr", m_lfsr, 16'hACE1);
    rst_n = 1'b1;
    @(negedge clk);

    // 2. greedy with tie, plus other directed rows
    run_req({16'd5, 16'd9, 16'd9, 16'd2}, 16'd0, 1'b1, lat, a, e, mx);
    check("tie_latency", lat, 5);
    check("tie_action", a, 4'd3);
    check("tie_max", mx, 16'd9);
    check("tie_explored", e, 1'b0);
    run_req({16'd4, 16'd3, 16'd2, 16'd1}, 16'd0, 1'b1, lat, a, e, mx);
    check("ramp_action", a, 4'd1);
    check("ramp_max", mx, 16'd4);
    run_req({16'd0, 16'd0, 16'd0, 16'hFFFF}, 16'd0, 1'b1, lat, a, e, mx);
    check("slot0_action", a, 4'd4);
    check("slot0_max", mx, 16'hFFFF);
    run_req({16'd7, 16'd7, 16'd7, 16'd7}, 16'd0, 1'b1, lat, a, e, mx);
    check("alleq_action", a, 4'd4);

    // 3. exploration statistics, back-to-back
    for (int i = 0; i < 16; i++) hist[i] = 0;
    cnt = 0; cyc = 0; nexp = 0; nonzero_max = 0;
    q_values = '0; epsilon = 16'hFFFF; req_valid = 1'b1; action_ready = 1'b1;
    while (cnt < 2000 && cyc < 30000) begin
      @(negedge clk);
      cyc++;
      if (action_valid) begin
        cnt++;
        if (explored) nexp++;
        if (max_value != 16'd0) nonzero_max++;
        hist[action]++;
      end
    end
    req_valid = 1'b0;
    @(negedge clk);
    action_ready = 1'b0;
    check("explore_count_results", cnt, 2000);
    check("explore_ratio_ok", (nexp >= 1980), 1'b1);
    check("explore_max_zero", nonzero_max, 0);
    for (int i = 1; i <= 4; i++)
      check($sformatf("explore_hist_%0d", i), (hist[i] >= 400 && hist[i] <= 600), 1'b1);
    repeat (3) @(negedge clk);

    // 4. backpressure
    run_req({16'd8, 16'd1, 16'd8, 16'd3}, 16'd0, 1'b0, lat, a, e, mx);
    check("bp_action", a, 4'd3);
    check("bp_max", mx, 16'd8);
    q_values = {4{16'hFFFF}};
    req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_req_ready", req_ready, 1'b0);
      check("bp_hold", {action_valid, action, explored, max_value}, {1'b1, 4'd3, 1'b0, 16'd8});
    end
    action_ready = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    action_ready = 1'b0;
    check("bp_release_ready", req_ready, 1'b1);
    check("bp_release_valid", action_valid, 1'b0);
    seen = 0;
    repeat (N + 3) begin
      @(negedge clk);
      if (action_valid) seen++;
    end
    check("bp_no_second_capture", seen, 0);

    // 5. parametrised instance
    q6 = {6{8'h7F}}; eps6 = 8'd0; req_valid6 = 1'b1;
    check("p6_req_ready", req_ready6, 1'b1);
    @(posedge clk);
    @(negedge clk);
    req_valid6 = 1'b0;
    lat = 0;
    while (!action_valid6 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("p6_latency", lat, 7);
    check("p6_action", action6, 3'd6);
    check("p6_max", max6, 8'h7F);
    check("p6_explored", explored6, 1'b0);
    action_ready6 = 1'b1;
    @(negedge clk);
    action_ready6 = 1'b0;
    check("p6_back_idle", req_ready6, 1'b1);

    // 6a. abort in the middle of the scan
    q_values = {16'd1, 16'd2, 16'd3, 16'd4}; epsilon = 16'd0; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_req_ready", req_ready, 1'b1);
    check("abort_valid", action_valid, 1'b0);
    rst_n = 1'b1;
    seen = 0;
    repeat (N + 4) begin
      @(negedge clk);
      if (action_valid) seen++;
    end
    check("abort_no_result", seen, 0);

    // 6b. zero seed falls back to the default
    seed_load = 1'b1; seed = 16'd0;
    @(negedge clk);
    seed_load = 1'b0;
    check("seed0_lfsr", dut.r_lfsr, 16'hACE1);

    // 6c. repeatable sequence from an explicit seed
    for (int run = 0; run < 2; run++) begin
      seed_load = 1'b1; seed = 16'h1234;
      @(negedge clk);
      seed_load = 1'b0;
      check("seed1234_lfsr", dut.r_lfsr, 16'h1234);
      for (int i = 0; i < 8; i++) begin
        run_req({16'd4, 16'd3, 16'd2, 16'd1}, 16'h8000, 1'b1, lat, a, e, mx);
        if (run == 0) seq1[i] = {e, a};
        else          seq2[i] = {e, a};
      end
    end
    for (int i = 0; i < 8; i++)
      check($sformatf("seed_repeat_%0d", i), seq2[i], seq1[i]);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
